uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin controller that shares one `uart_tx` transmitter between `NUM_REQ` independent byte sources. It grants one requester at a time, launches the byte into `uart_tx` with a single-cycle `tx_valid` pulse, and tracks `tx_busy` until the frame completes. It then re-arbitrates. The block sits between the on-chip producers and `uart_tx`; `baud_gen` and `uart_rx` are untouched.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..16.
- `BUSY_TIMEOUT`, default 16: cycles to wait for `tx_busy` to rise after launch before aborting.
- `clk` in 1: system clock, 50 MHz nominal.
- `rst_n` in 1: reset. Asynchronous, active-low.
- `req_valid` in `NUM_REQ`: per-requester byte available. Held until accepted.
- `req_data` in `NUM_REQ*8`: requester i byte on bits `[8i+7:8i]`. Stable while `req_valid[i]` is high.
- `req_ready` out `NUM_REQ`: one-hot accept strobe. The byte transfers on `req_valid[i] && req_ready[i]`.
- `tx_valid` out 1: launch pulse to `uart_tx`.
- `tx_data` out 8: byte to `uart_tx`.
- `tx_busy` in 1: busy flag from `uart_tx`.
- `grant_id` out `$clog2(NUM_REQ)`: index of the current or last granted requester.
- `active` out 1: high from the grant cycle until the transaction ends.
- `err_timeout` out 1: one-cycle pulse when `tx_busy` never rose.

## Operation
- **States:** IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
- **IDLE, grant condition:** grant when `|req_valid` and `!tx_busy`.
  - Winner is the first valid index searched from `last_grant+1` upward, wrapping modulo `NUM_REQ`.
  - `req_ready[winner]` is high for that cycle only, combinational from state, `req_valid` and pointer.
  - On the clock edge: byte registered into `tx_data`, `grant_id`/`last_grant` updated to the winner, `active` set, go to LAUNCH.
- **LAUNCH:** `tx_valid=1` for exactly one cycle. Clear the timeout counter and go to WAIT_BUSY.
- **WAIT_BUSY:**
  - If `tx_busy=1`, go to WAIT_DONE.
  - Otherwise increment the counter. When it reaches `BUSY_TIMEOUT`, pulse `err_timeout`, drop the transaction, clear `active`, go to IDLE.
- **WAIT_DONE:** on `tx_busy=0`, the transaction is complete. Clear `active` and go to IDLE.
- **Fairness:** a requester holding `req_valid` high waits at most `NUM_REQ-1` other transactions.
- **No-grant cases:** `req_valid` deasserting before grant is legal; no grant occurs. `tx_busy=1` while in IDLE (external use) blocks granting.
- **Reset values:** `req_ready=0`, `tx_valid=0`, `tx_data=8'h00`, `grant_id=0`, `active=0`, `err_timeout=0`, state IDLE, `last_grant=NUM_REQ-1` so requester 0 wins first.
- **Reset mid-operation:** everything returns to reset values immediately. The byte in flight is lost, and `uart_tx` is reset by the same `rst_n`.
- **Counter width:** `$clog2(BUSY_TIMEOUT+1)` bits, saturating, no wrap.

## Timing
- Grant in cycle N (`req_ready` high). `tx_valid` is high in N+1. `tx_data` is valid from N+1 and held until the next grant.
- Earliest `tx_busy` sample is N+2. The timeout fires in cycle N+1+`BUSY_TIMEOUT` if busy is never seen.
- After `tx_busy` falls in cycle M, the block is in IDLE in M+1 and can grant in M+1. Back-to-back overhead is 2 cycles plus the `uart_tx` busy-rise latency.
- A `req_valid` rising in the same cycle as a grant to another requester is considered at the next IDLE.

## Configuration
- `UART_ARB_TAG_EN` defined:
  - Each transaction sends two frames: header `{4'hA, 4'(grant_id)}`, then the data byte.
  - Sequence: LAUNCH/WAIT_BUSY/WAIT_DONE for the header, then LAUNCH/WAIT_BUSY/WAIT_DONE for the data. A phase flag selects which byte drives `tx_data`.
  - `active` spans both frames.
  - A timeout in either frame aborts the whole transaction.
- `UART_ARB_TAG_EN` undefined: one frame per transaction, data only. No phase flag or header register exists.

## Structure
- Package `uart_pkg` holds:
  - `arb_state_t` enum (IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE).
  - `UART_TAG_PREFIX = 4'hA`.
  - `UART_DATA_W = 8`.
- Sub-module `rr_arbiter` (parameter `NUM_REQ`) contains:
  - Combinational rotate-priority search of `req_valid` from `last_grant+1`.
  - Outputs: one-hot grant and encoded index.
  - Pointer register stays in `uart_tx_arbiter`.

## Test plan
- **Single requester:** after reset, `req_valid[2]=1` with `8'hA5` -> `req_ready[2]` for 1 cycle, `tx_valid` the next cycle with `tx_data=8'hA5`, `uart_rx` receives `0xA5`, `active` falls after `tx_busy` falls.
- **All four requesting:** req 0..3 hold `8'h00/8'h3C/8'hFF/8'h5A` -> grant order 0,1,2,3 and `uart_rx` sequence `00,3C,FF,5A`. Next grant after req1 re-asserts, with req3 still valid, is req3 (wrap honoured).
- **Blocking:** `tx_busy` forced high while idle with `req_valid[0]=1` -> no `req_ready` until it drops. With `tx_busy` stuck at 0 after launch -> `err_timeout` pulses at launch+16, `active=0`, next requester is granted.
- **Reset mid-frame:** `rst_n` low during WAIT_DONE -> all outputs at reset values within the same cycle. First grant after release goes to requester 0.
- **`UART_ARB_TAG_EN` defined:** req1 sends `8'hC3` -> `uart_rx` receives `0xA1` then `0xC3`, with `active` high across both frames.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Optional header framing is enabled with the UART_ARB_TAG_EN macro.
package uart_pkg;

   localparam int         UART_DATA_W     = 8;
   localparam logic [3:0] UART_TAG_PREFIX = 4'hA;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LAUNCH    = 2'd1,
      WAIT_BUSY = 2'd2,
      WAIT_DONE = 2'd3
   } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority search: the first asserted request after last_grant_i wins,
// wrapping modulo NUM_REQ.
module rr_arbiter
   import uart_pkg::*;
#(
   parameter int NUM_REQ = 4
)(
   input  logic [NUM_REQ-1:0]         req_valid_i,
   input  logic [$clog2(NUM_REQ)-1:0] last_grant_i,
   output logic [NUM_REQ-1:0]         grant_o,
   output logic [$clog2(NUM_REQ)-1:0] grant_idx_o,
   output logic                       grant_any_o
);

   localparam int IDX_W = $clog2(NUM_REQ);

   always_comb begin
      logic [IDX_W-1:0] idx;
      logic             found;
      idx         = '0;
      found       = 1'b0;
      grant_o     = '0;
      grant_idx_o = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = IDX_W'((int'(last_grant_i) + k) % NUM_REQ);
         if (!found && req_valid_i[idx]) begin
            found       = 1'b1;
            grant_idx_o = idx;
         end
      end
      if (found) grant_o[grant_idx_o] = 1'b1;
      grant_any_o = found;
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one uart_tx between NUM_REQ byte sources.
// Define UART_ARB_TAG_EN to prefix each byte with a {4'hA, grant_id} header frame.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NUM_REQ      = 4,
   parameter int BUSY_TIMEOUT = 16
)(
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NUM_REQ-1:0]             req_valid,
   input  logic [NUM_REQ*UART_DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]             req_ready,
   output logic                           tx_valid,
   output logic [UART_DATA_W-1:0]         tx_data,
   input  logic                           tx_busy,
   output logic [$clog2(NUM_REQ)-1:0]     grant_id,
   output logic                           active,
   output logic                           err_timeout,
   output logic [1:0]                     dbg_state
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BUSY_TIMEOUT);

   arb_state_t             state_q, state_d;
   logic [IDX_W-1:0]       last_grant_q, last_grant_d;
   logic [IDX_W-1:0]       grant_id_q, grant_id_d;
   logic [UART_DATA_W-1:0] data_q, data_d;
   logic                   active_q, active_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
`ifdef UART_ARB_TAG_EN
   logic                   phase_q, phase_d;
   logic [UART_DATA_W-1:0] hdr_q, hdr_d;
`endif

   logic [NUM_REQ-1:0]     arb_grant;
   logic [IDX_W-1:0]       arb_idx;
   logic                   arb_any;
   logic                   grant_fire;
   logic [UART_DATA_W-1:0] data_sel;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .req_valid_i  (req_valid),
      .last_grant_i (last_grant_q),
      .grant_o      (arb_grant),
      .grant_idx_o  (arb_idx),
      .grant_any_o  (arb_any)
   );

   // rst_n gates the strobe so req_ready reads 0 while reset is held.
   assign grant_fire  = rst_n && (state_q == IDLE) && arb_any && !tx_busy;
   assign req_ready   = grant_fire ? arb_grant : '0;
   assign tx_valid    = (state_q == LAUNCH);
   assign err_timeout = (state_q == WAIT_BUSY) && !tx_busy && (cnt_q == CNT_LAST);
   assign active      = active_q;
   assign grant_id    = grant_id_q;
   assign dbg_state   = state_q;

`ifdef UART_ARB_TAG_EN
   assign tx_data = phase_q ? data_q : hdr_q;
`else
   assign tx_data = data_q;
`endif

   always_comb begin
      data_sel = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (arb_idx == IDX_W'(i)) data_sel = req_data[i*UART_DATA_W +: UART_DATA_W];
      end
   end

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      grant_id_d   = grant_id_q;
      data_d       = data_q;
      active_d     = active_q;
      cnt_d        = cnt_q;
`ifdef UART_ARB_TAG_EN
      phase_d      = phase_q;
      hdr_d        = hdr_q;
`endif
      case (state_q)
         IDLE: begin
            if (grant_fire) begin
               data_d       = data_sel;
               grant_id_d   = arb_idx;
               last_grant_d = arb_idx;
               active_d     = 1'b1;
               state_d      = LAUNCH;
`ifdef UART_ARB_TAG_EN
               hdr_d        = {UART_TAG_PREFIX, 4'(arb_idx)};
               phase_d      = 1'b0;
`endif
            end
         end
         LAUNCH: begin
            cnt_d   = '0;
            state_d = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
            if (tx_busy) begin
               state_d = WAIT_DONE;
            end else if (err_timeout) begin
               active_d = 1'b0;
               state_d  = IDLE;
            end
         end
         WAIT_DONE: begin
            if (!tx_busy) begin
`ifdef UART_ARB_TAG_EN
               if (!phase_q) begin
                  phase_d = 1'b1;
                  state_d = LAUNCH;
               end else begin
                  active_d = 1'b0;
                  state_d  = IDLE;
               end
`else
               active_d = 1'b0;
               state_d  = IDLE;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         last_grant_q <= IDX_W'(NUM_REQ - 1);
         grant_id_q   <= '0;
         data_q       <= '0;
         active_q     <= 1'b0;
         cnt_q        <= '0;
`ifdef UART_ARB_TAG_EN
         phase_q      <= 1'b0;
         hdr_q        <= '0;
`endif
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         grant_id_q   <= grant_id_d;
         data_q       <= data_d;
         active_q     <= active_d;
         cnt_q        <= cnt_d;
`ifdef UART_ARB_TAG_EN
         phase_q      <= phase_d;
         hdr_q        <= hdr_d;
`endif
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter: the bench plays the requesters and uart_tx,
// predicts grants and frames at transaction level, and scoreboards tx_data.
module tb_uart_tx_arbiter;
   import uart_pkg::*;

   localparam int NR    = 4;
   localparam int TO    = 16;
   localparam int NEVER = 32'h7fff_ffff;
`ifdef UART_ARB_TAG_EN
   localparam int FRAMES = 2;
`else
   localparam int FRAMES = 1;
`endif

   logic            clk = 1'b0;
   logic            rst_n;
   logic [NR-1:0]   req_valid;
   logic [NR*8-1:0] req_data;
   logic [NR-1:0]   req_ready;
   logic            tx_valid;
   logic [7:0]      tx_data;
   logic            tx_busy;
   logic [1:0]      grant_id;
   logic            active;
   logic            err_timeout;
   logic [1:0]      dbg_state;

   uart_tx_arbiter #(.NUM_REQ(NR), .BUSY_TIMEOUT(TO)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_ready   (req_ready),
      .tx_valid    (tx_valid),
      .tx_data     (tx_data),
      .tx_busy     (tx_busy),
      .grant_id    (grant_id),
      .active      (active),
      .err_timeout (err_timeout),
      .dbg_state   (dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1000000;
      $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
      $fatal(1, "watchdog expired");
   end

   // scoreboard and reference model state
   int checks = 0;
   int failures = 0;
   logic [7:0] exp_q[$];
   bit  m_free, mon_en, rand_en, force_to;
   int  m_last, m_gid, m_launch, m_err, m_release, frames_left;
   int  b_on, b_off, ext_left;
   logic [NR-1:0] acc;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         failures++;
         $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp_v);
      end
   endtask

   function automatic int rr_pick(input logic [NR-1:0] v, input int last);
      for (int k = 1; k <= NR; k++) begin
         int idx;
         idx = (last + k) % NR;
         if (((int'(v) >> idx) & 1) == 1) return idx;
      end
      return -1;
   endfunction

   task automatic reset_model();
      m_free = 1'b1; m_last = NR - 1; m_gid = 0;
      m_launch = -1; m_err = -1; m_release = NEVER; frames_left = 0;
      exp_q.delete();
      b_on = 0; b_off = 0; ext_left = 0; acc = '0; force_to = 1'b0;
   endtask

   // monitor: model of grants, launches and timeouts, checked every cycle
   always @(negedge clk) begin : mon
      logic [NR-1:0] exp_rdy;
      logic [7:0]    e;
      int            w, l, d;
      if (mon_en && rst_n) begin
         if (!m_free && cyc == m_release) m_free = 1'b1;
         chk("active", 32'(active), 32'(!m_free));
         chk("grant_id", 32'(grant_id), 32'(m_gid));
         chk("err_timeout", 32'(err_timeout), 32'(cyc == m_err));
         chk("tx_valid", 32'(tx_valid), 32'(cyc == m_launch));
         if (tx_valid) begin
            if (exp_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL tx_data cyc=%0d actual=%0h expected=none", cyc, tx_data);
            end else begin
               e = exp_q.pop_front();
               chk("tx_data", 32'(tx_data), 32'(e));
            end
         end
         if (cyc == m_launch) begin
            frames_left--;
            if (force_to || $urandom_range(0, 9) == 0) begin
               force_to  = 1'b0;
               m_err     = cyc + TO;
               m_release = cyc + TO + 1;
               while (frames_left > 0) begin
                  void'(exp_q.pop_back());
                  frames_left--;
               end
            end else begin
               l = $urandom_range(1, 3);
               d = $urandom_range(2, 6);
               b_on  = cyc + l;
               b_off = cyc + l + d;
               if (frames_left > 0) m_launch = b_off + 1;
               else m_release = b_off + 1;
            end
         end
         exp_rdy = '0;
         if (m_free && (|req_valid) && !tx_busy) begin
            w = rr_pick(req_valid, m_last);
            exp_rdy = NR'(1) << w;
`ifdef UART_ARB_TAG_EN
            exp_q.push_back({4'hA, 4'(w)});
`endif
            exp_q.push_back(req_data[w*8 +: 8]);
            m_last = w; m_gid = w; m_free = 1'b0;
            m_release = NEVER; m_launch = cyc + 1; frames_left = FRAMES;
         end
         chk("req_ready", 32'(req_ready), 32'(exp_rdy));
         acc = req_ready & req_valid;
      end
   end

   // driver: requesters and the uart_tx busy behaviour
   task automatic step();
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) begin
         if (acc[i]) req_valid[i] = 1'b0;
         else if (rand_en && req_valid[i] && $urandom_range(0, 63) == 0) req_valid[i] = 1'b0;
         if (rand_en && !req_valid[i] && $urandom_range(0, 5) == 0) begin
            req_data[i*8 +: 8] = 8'($urandom);
            req_valid[i] = 1'b1;
         end
      end
      acc = '0;
      if (ext_left > 0) ext_left--;
      else if (rand_en && m_free && cyc >= b_off && $urandom_range(0, 39) == 0)
         ext_left = $urandom_range(1, 4);
      tx_busy = (cyc >= b_on && cyc < b_off) || (ext_left > 0);
   endtask

   task automatic wait_quiet(input int max_cyc);
      int n;
      n = 0;
      while (!(req_valid == '0 && m_free && ext_left == 0) && n < max_cyc) begin
         step();
         n++;
      end
      checks++;
      if (n >= max_cyc) begin
         failures++;
         $display("FAIL wait_quiet cyc=%0d actual=busy required=idle_within_%0d", cyc, max_cyc);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_req_ready"}, 32'(req_ready), 32'(0));
      chk({tag, "_tx_valid"}, 32'(tx_valid), 32'(0));
      chk({tag, "_tx_data"}, 32'(tx_data), 32'(8'h00));
      chk({tag, "_grant_id"}, 32'(grant_id), 32'(0));
      chk({tag, "_active"}, 32'(active), 32'(0));
      chk({tag, "_err"}, 32'(err_timeout), 32'(0));
      chk({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
   endtask

   initial begin
      int n;
      rst_n = 1'b0; req_valid = '0; req_data = '0; tx_busy = 1'b0;
      mon_en = 1'b0; rand_en = 1'b0;
      reset_model();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      mon_en = 1'b1;

      // all four requesting from reset
      req_data = {8'h5A, 8'hFF, 8'h3C, 8'h00};
      req_valid = 4'hF;
      wait_quiet(400);

      // single requester 2
      req_data[23:16] = 8'hA5;
      req_valid = 4'b0100;
      wait_quiet(200);

      // external busy blocks granting
      ext_left = 6;
      req_data[7:0] = 8'h81;
      req_valid = 4'b0001;
      wait_quiet(200);

      // forced timeout, then another requester follows
      force_to = 1'b1;
      req_data[31:24] = 8'h77;
      req_data[15:8] = 8'h19;
      req_valid = 4'b1010;
      wait_quiet(300);

      rand_en = 1'b1;
      repeat (3000) step();

      // reset while a frame is in flight
      n = 0;
      while (!(!m_free && cyc > b_on && cyc < b_off) && n < 2000) begin
         step();
         n++;
      end
      checks++;
      if (n >= 2000) begin
         failures++;
         $display("FAIL find_frame cyc=%0d actual=none required=frame_in_flight", cyc);
      end
      #2;
      rst_n = 1'b0;
      mon_en = 1'b0;
      rand_en = 1'b0;
      #1;
      check_reset_outputs("midreset");
      reset_model();
      tx_busy = 1'b0;
      if (!req_valid[0]) begin
         req_data[7:0] = 8'h42;
         req_valid[0] = 1'b1;
      end
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      mon_en = 1'b1;

      rand_en = 1'b1;
      repeat (1000) step();
      rand_en = 1'b0;
      wait_quiet(800);
      repeat (2) step();
      chk("exp_q_drained", 32'(exp_q.size()), 32'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
